// File: rtl/stream_to_mem_dma.sv
// Stream-to-memory DMA: pops words from an upstream FIFO and writes them to consecutive byte addresses.
// Optional sticky completion interrupt is compiled in with `define DMA_IRQ_EN.
module stream_to_mem_dma #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    cfg_start,
  input  logic [ADDR_WIDTH-1:0]   cfg_addr,
  input  logic [LEN_WIDTH-1:0]    cfg_len,
  output logic                    busy,
  output logic                    done,
  input  logic [DATA_WIDTH-1:0]   in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic                    mem_valid,
  input  logic                    mem_ready,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_wstrb,
  output logic                    irq,
  input  logic                    irq_clear
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH-1:0] ADDR_STEP = ADDR_WIDTH'(STRB_WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    WRITE,
    DONE
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q;
  logic [LEN_WIDTH-1:0]  rem_q;
  logic [DATA_WIDTH-1:0] data_q;

  wire start_ok  = (state_q == IDLE) && cfg_start && (cfg_len != '0);
  wire last_word = (rem_q == LEN_WIDTH'(1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // NOTE: every output and next-state signal gets a default first, so no
  // path through the case can leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    busy      = 1'b1;
    done      = 1'b0;
    in_ready  = 1'b0;
    mem_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (cfg_start) state_d = (cfg_len == '0) ? DONE : FETCH;
      end
      FETCH: begin
        in_ready = 1'b1;
        if (in_valid) state_d = WRITE;
      end
      WRITE: begin
        mem_valid = 1'b1;
        if (mem_ready) state_d = last_word ? DONE : FETCH;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: the data register is a single word, not a memory array, so it is
  // cheap to reset and gives mem_wdata a defined value out of reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      ptr_q  <= '0;
      rem_q  <= '0;
      data_q <= '0;
    end else begin
      if (start_ok) begin
        ptr_q <= cfg_addr;
        rem_q <= cfg_len;
      end
      if (state_q == FETCH && in_valid) data_q <= in_data;
      if (state_q == WRITE && mem_ready) begin
        ptr_q <= ptr_q + ADDR_STEP;   // wraps modulo 2^ADDR_WIDTH
        rem_q <= rem_q - LEN_WIDTH'(1);
      end
    end
  end

  assign mem_addr  = ptr_q;
  assign mem_wdata = data_q;
  assign mem_wstrb = '1;

`ifdef DMA_IRQ_EN
  logic irq_q;

  // Set has priority so a clear arriving with done cannot lose the event.
  always_ff @(posedge clk) begin
    if (!resetn)        irq_q <= 1'b0;
    else if (done)      irq_q <= 1'b1;
    else if (irq_clear) irq_q <= 1'b0;
  end

  assign irq = irq_q;
`else
  // Interrupt compiled out: irq is constant zero and irq_clear has no effect.
  assign irq = 1'b0 & irq_clear;
`endif

endmodule

// File: tb/tb_stream_to_mem_dma.sv
// Self-checking bench for stream_to_mem_dma: transaction-level model plus directed scenarios.
// Interrupt expectations follow `define DMA_IRQ_EN when the bench is built with it.
module tb_stream_to_mem_dma;

  logic        clk = 1'b0;
  logic        resetn;
  logic        cfg_start;
  logic [31:0] cfg_addr;
  logic [15:0] cfg_len;
  logic        busy, done;
  logic [31:0] in_data;
  logic        in_valid, in_ready;
  logic        mem_valid, mem_ready;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        irq, irq_clear;

  always #5 clk = ~clk;

  stream_to_mem_dma dut (
    .clk(clk), .resetn(resetn),
    .cfg_start(cfg_start), .cfg_addr(cfg_addr), .cfg_len(cfg_len),
    .busy(busy), .done(done),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .irq(irq), .irq_clear(irq_clear)
  );

  // Upstream source: word k of the run is 0xDA7A_0000 + k.
  logic [15:0] src_idx = '0;
  assign in_data = {16'hDA7A, src_idx};
  always @(posedge clk) if (in_valid && in_ready) src_idx <= src_idx + 16'd1;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Transaction-level model: outstanding transfer, popped words awaiting write.
  bit          mon_en = 1'b0;
  bit          m_active = 1'b0, m_done_due = 1'b0, m_irq = 1'b0;
  logic [31:0] m_ptr = '0;
  int          m_rem = 0;
  logic [31:0] m_words[$];

  // Logs that the directed scenarios inspect.
  logic [31:0] wr_addr[$], wr_data[$];
  int          wr_cyc[$];
  int          start_cyc = -1, done_cyc = -1, first_ir_cyc = -1;
  int          n_inready = 0, n_mvalid = 0;

  task automatic clear_logs();
    wr_addr.delete(); wr_data.delete(); wr_cyc.delete();
    start_cyc = -1; done_cyc = -1; first_ir_cyc = -1;
    n_inready = 0; n_mvalid = 0;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      bit next_due;
      check("busy", busy, m_active || m_done_due);
      check("done", done, m_done_due);
      check("wstrb", mem_wstrb, 4'hF);
      check("irq", irq, m_irq);
      if (!m_active) begin
        check("in_ready_idle", in_ready, 1'b0);
        check("mem_valid_idle", mem_valid, 1'b0);
      end
      if (in_ready) check("pop_overlap", m_words.size(), 0);
      if (mem_valid) begin
        check("write_word_held", m_words.size(), 1);
        check("mem_addr", mem_addr, m_ptr);
        if (m_words.size() > 0) check("mem_wdata", mem_wdata, m_words[0]);
        check("ready_in_write", in_ready, 1'b0);
      end
      if (in_ready) begin
        n_inready++;
        if (first_ir_cyc < 0) first_ir_cyc = cyc;
      end
      if (mem_valid) n_mvalid++;
      if (done) done_cyc = cyc;

      if (!resetn) begin
        m_active = 1'b0; m_done_due = 1'b0; m_irq = 1'b0; m_ptr = '0; m_rem = 0;
        m_words.delete();
      end else begin
        next_due = 1'b0;
`ifdef DMA_IRQ_EN
        if (m_done_due)     m_irq = 1'b1;
        else if (irq_clear) m_irq = 1'b0;
`endif
        if (!m_active && !m_done_due && cfg_start) begin
          start_cyc = cyc;
          if (cfg_len == 16'd0) next_due = 1'b1;
          else begin
            m_active = 1'b1; m_ptr = cfg_addr; m_rem = int'(cfg_len);
          end
        end
        if (in_ready && in_valid) m_words.push_back(in_data);
        if (mem_valid && mem_ready) begin
          wr_addr.push_back(mem_addr); wr_data.push_back(mem_wdata); wr_cyc.push_back(cyc);
          if (m_words.size() > 0) void'(m_words.pop_front());
          m_ptr = m_ptr + 32'd4;
          m_rem--;
          if (m_rem == 0) begin
            m_active = 1'b0;
            next_due = 1'b1;
          end
        end
        m_done_due = next_due;
      end
    end
  end

  task automatic start_xfer(input logic [31:0] addr, input logic [15:0] len);
    @(posedge clk); #1;
    clear_logs();
    cfg_start = 1'b1; cfg_addr = addr; cfg_len = len;
    @(posedge clk); #1;
    cfg_start = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    for (int i = 0; i < limit && done_cyc < 0; i++) @(negedge clk);
    check("done_timeout", done_cyc >= 0, 1'b1);
  endtask

  task automatic wait_mem_valid_posedge(input int limit);
    bit seen = 1'b0;
    for (int i = 0; i < limit && !seen; i++) begin
      @(posedge clk); #1;
      seen = mem_valid;
    end
    check("mem_valid_timeout", seen, 1'b1);
  endtask

  initial begin
    resetn = 1'b0; cfg_start = 1'b0; cfg_addr = '0; cfg_len = '0;
    in_valid = 1'b0; mem_ready = 1'b0; irq_clear = 1'b0;
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    mon_en = 1'b1;

    // Reset state
    @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_mem_valid", mem_valid, 1'b0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    check("rst_irq", irq, 1'b0);

    // Three-word burst at 0x1000 with both sides always ready
    in_valid = 1'b1; mem_ready = 1'b1;
    start_xfer(32'h1000, 16'd3);
    wait_done(40);
    check("burst_nwrites", wr_addr.size(), 3);
    if (wr_addr.size() >= 3) begin
      check("burst_addr0", wr_addr[0], 32'h1000);
      check("burst_addr1", wr_addr[1], 32'h1004);
      check("burst_addr2", wr_addr[2], 32'h1008);
      check("burst_data0", wr_data[0], 32'hDA7A_0000);
      check("burst_data2", wr_data[2], 32'hDA7A_0002);
      check("burst_done_lat", done_cyc, wr_cyc[2] + 1);
    end
    check("burst_ready_lat", first_ir_cyc, start_cyc + 1);
    @(negedge clk);
    check("burst_busy_after", busy, 1'b0);

    // Zero-length start goes straight to done
    start_xfer(32'h5000, 16'd0);
    wait_done(10);
    check("len0_done_lat", done_cyc, start_cyc + 1);
    check("len0_no_in_ready", n_inready, 0);
    check("len0_no_mem_valid", n_mvalid, 0);

    // Memory stalls five extra cycles in WRITE
    mem_ready = 1'b0;
    start_xfer(32'h2000, 16'd1);
    for (int i = 0; i < 20 && !mem_valid; i++) @(negedge clk);
    check("stall_reach_write", mem_valid, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_valid", mem_valid, 1'b1);
      check("stall_addr", mem_addr, 32'h2000);
      check("stall_data", mem_wdata, 32'hDA7A_0003);
      check("stall_in_ready", in_ready, 1'b0);
    end
    @(posedge clk); #1 mem_ready = 1'b1;
    wait_done(10);

    // Address wraps past the top of the space
    start_xfer(32'hFFFF_FFFC, 16'd2);
    wait_done(40);
    check("wrap_nwrites", wr_addr.size(), 2);
    if (wr_addr.size() >= 2) begin
      check("wrap_addr0", wr_addr[0], 32'hFFFF_FFFC);
      check("wrap_addr1", wr_addr[1], 32'h0000_0000);
      check("wrap_data1", wr_data[1], 32'hDA7A_0005);
    end

    // Reset while word 2 of 4 is being written
    mem_ready = 1'b0;
    start_xfer(32'h3000, 16'd4);
    wait_mem_valid_posedge(20);
    mem_ready = 1'b1;
    @(posedge clk); #1 mem_ready = 1'b0;
    wait_mem_valid_posedge(20);
    check("rst_mid_one_write", wr_addr.size(), 1);
    resetn = 1'b0;
    @(posedge clk); #1 resetn = 1'b1;
    @(negedge clk);
    check("rst_mid_mem_valid", mem_valid, 1'b0);
    check("rst_mid_busy", busy, 1'b0);
    repeat (4) @(negedge clk);
    check("rst_mid_no_done", done_cyc, -1);

    // Fresh single-word transfer after the abort, with clear racing done
    mem_ready = 1'b1;
    @(posedge clk); #1 irq_clear = 1'b1;
    @(posedge clk); #1 irq_clear = 1'b0;
    start_xfer(32'h4000, 16'd1);
    begin
      bit seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
        seen = done;
        if (!seen) begin @(posedge clk); #1; end
      end
      check("post_rst_done_seen", seen, 1'b1);
    end
    irq_clear = 1'b1;
    @(posedge clk); #1 irq_clear = 1'b0;
    @(negedge clk);
    check("post_rst_addr", wr_addr.size() > 0 ? wr_addr[0] : 32'hDEAD_BEEF, 32'h4000);
    check("post_rst_data", wr_data.size() > 0 ? wr_data[0] : 32'hDEAD_BEEF, 32'hDA7A_0008);
`ifdef DMA_IRQ_EN
    check("irq_set_wins", irq, 1'b1);
`else
    check("irq_tied_low", irq, 1'b0);
`endif
    @(posedge clk); #1 irq_clear = 1'b1;
    @(posedge clk); #1 irq_clear = 1'b0;
    @(negedge clk);
    check("irq_cleared", irq, 1'b0);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/stream_to_mem_dma.md
STREAM_TO_MEM_DMA -- requirements
Module: stream_to_mem_dma

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, byte-address width of memory port and cfg_addr.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, stream/memory word width; multiple of 8.
REQ-003 SHALL have parameter LEN_WIDTH, default 16, width of transfer word count.
REQ-004 clk  input  1  clock; all logic on rising edge.
REQ-005 resetn  input  1  reset, synchronous, active-low.
REQ-006 cfg_start  input  1  one-cycle request to begin a transfer.
REQ-007 cfg_addr  input  ADDR_WIDTH  destination byte address, sampled on accepted start.
REQ-008 cfg_len  input  LEN_WIDTH  number of words to move, sampled on accepted start.
REQ-009 busy  output  1  high while a transfer is in progress.
REQ-010 done  output  1  one-cycle completion pulse.
REQ-011 in_data  input  DATA_WIDTH  stream word from upstream FIFO read side.
REQ-012 in_valid  input  1  upstream word available.
REQ-013 in_ready  output  1  block pops the word this cycle when in_valid also high.
REQ-014 mem_valid  output  1  memory write request.
REQ-015 mem_ready  input  1  memory accepts the request this cycle.
REQ-016 mem_addr  output  ADDR_WIDTH  write byte address.
REQ-017 mem_wdata  output  DATA_WIDTH  write data.
REQ-018 mem_wstrb  output  DATA_WIDTH/8  byte strobes; all ones during any request.
REQ-019 irq  output  1  sticky completion interrupt (see Configuration).
REQ-020 irq_clear  input  1  clears irq.

Function
REQ-021 SHALL implement FSM states IDLE, FETCH, WRITE, DONE.
REQ-022 IDLE: busy=0; cfg_start with cfg_len!=0 latches addr/len into internal pointer/remaining-count registers, next state FETCH.
REQ-023 IDLE: cfg_start with cfg_len==0 SHALL go to DONE without touching in_* or mem_*.
REQ-024 cfg_start outside IDLE SHALL be ignored; latched addr/len unchanged.
REQ-025 FETCH: in_ready=1, busy=1; on in_valid capture in_data into data register, next state WRITE; otherwise hold.
REQ-026 in_ready SHALL be 0 in every state other than FETCH.
REQ-027 WRITE: mem_valid=1, busy=1; mem_addr, mem_wdata, mem_wstrb held stable until mem_ready sampled high.
REQ-028 On mem_ready in WRITE: pointer += DATA_WIDTH/8 modulo 2^ADDR_WIDTH (wraps silently), remaining -= 1; next FETCH if remaining was >1, else DONE.
REQ-029 DONE: done=1, busy=1 for exactly one cycle, next IDLE.
REQ-030 mem_valid SHALL be 0 outside WRITE; mem_addr/mem_wdata SHALL hold last values when idle.
REQ-031 Timing: start accepted at cycle t -> in_ready high at t+1; word popped at cycle f -> mem_valid high at f+1; mem_ready at cycle w with last word -> done high at w+1.
REQ-032 Throughput SHALL be at most one word per two cycles; no overlap of pop and write.

Reset
REQ-033 resetn low at a rising edge SHALL force state IDLE regardless of current state, abandoning any transfer with no done pulse.
REQ-034 Reset values: busy=0, done=0, in_ready=0, mem_valid=0, mem_addr=0, mem_wdata=0, irq=0; pointer and remaining count 0.
REQ-035 mem_wstrb SHALL be all ones combinationally independent of reset.

Configuration
REQ-036 Macro DMA_IRQ_EN SHALL compile the interrupt logic in or out.
REQ-037 With DMA_IRQ_EN: irq set the cycle after done; irq_clear clears it next cycle; simultaneous done and irq_clear leaves irq=1 (set wins).
REQ-038 Without DMA_IRQ_EN: irq tied to 0, irq_clear ignored; ports still present.

Verification
REQ-039 Start addr=0x1000 len=3, in_valid always 1, mem_ready always 1 -> writes to 0x1000,0x1004,0x1008 with pushed data, done one cycle after third write, busy low after.
REQ-040 len=0 start -> done at t+1, no in_ready, no mem_valid.
REQ-041 mem_ready held low 5 cycles in WRITE -> mem_addr/mem_wdata/mem_valid stable throughout, in_ready stays 0.
REQ-042 Start addr=0xFFFFFFFC len=2 -> second write at 0x00000000.
REQ-043 resetn low during WRITE of word 2 of 4 -> next cycle mem_valid=0, busy=0, no done; new start len=1 completes normally.
REQ-044 With DMA_IRQ_EN, irq_clear asserted same cycle as done -> irq=1; clear next cycle -> irq=0; without macro irq always 0.
